ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch unit directly upstream of the decode stage in the multi-cycle, non-pipelined RV32E core. It holds the architectural PC and issues one instruction-memory read per instruction over a valid/ready request/response bus. It presents the fetched word and its PC to decode via an ifu_valid/idu_ready handshake. It then waits for writeback to return the next PC before fetching again.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address.
CNT_WIDTH, 32, width of the retired-fetch performance counter.

Ports:
clk  input  1  clock.
rst  input  1  reset.
req_valid  output  1  imem read request valid.
req_ready  input  1  imem accepts request.
req_addr  output  32  imem read address (word aligned).
resp_valid  input  1  imem read data valid.
resp_ready  output  1  IFU accepts response.
resp_data  input  32  imem read data.
resp_err  input  1  imem access fault for this response.
ifu_valid  output  1  instr/pc valid to decode.
idu_ready  input  1  decode accepts instr/pc.
instr  output  32  fetched instruction.
pc  output  32  PC of instr.
fetch_err  output  1  instr is faulted (bus error or misaligned PC); qualified by ifu_valid.
wbu_valid  input  1  writeback completed current instruction; next_pc valid.
next_pc  input  32  PC of next instruction.
fetch_cnt  output  CNT_WIDTH  count of ifu_valid && idu_ready handshakes.

Behaviour:
- Reset is rst, synchronous, active-high. It dominates every other input in the same cycle.
- Reset values: state=REQ, pc=RESET_PC, instr=0, fetch_err=0, fetch_cnt=0. req_valid, resp_ready and ifu_valid follow state; the first request is asserted in the first cycle after rst deasserts.
- The imem shares rst. No outstanding transaction survives reset and no response-drop logic is required.
- State REQ: req_valid=1, req_addr=pc. Stay until req_valid && req_ready, then go to WAIT. req_addr is stable while waiting.
- State WAIT: resp_ready=1. On resp_valid, register instr=resp_data and fetch_err=resp_err, then go to OUT. If resp_err=1, instr is forced to 0.
- State OUT: ifu_valid=1. instr, pc and fetch_err are held stable until idu_ready. On ifu_valid && idu_ready, fetch_cnt increments (wraps modulo 2^CNT_WIDTH) and the FSM goes to EXEC.
- State EXEC: all bus outputs are 0 and ifu_valid=0. On wbu_valid, pc<=next_pc.
  - If next_pc[1:0]==0, go to REQ.
  - Otherwise do not issue a request: set instr=0 and fetch_err=1, then go to OUT.
- wbu_valid outside EXEC is ignored, with no pc change.
- req_ready outside REQ, resp_valid outside WAIT, and idu_ready outside OUT are ignored.
- Latency:
  - wbu_valid to req_valid: 1 cycle.
  - Response accept to ifu_valid: 1 cycle.
  - Minimum loop with zero-wait imem and always-ready decode: 4 cycles per instruction (REQ, WAIT, OUT, EXEC).
- ifu_valid must never depend combinationally on idu_ready. req_valid must never depend combinationally on req_ready.
- pc and instr are registers; neither changes in REQ, WAIT or OUT except as stated.

Test Plan:
- Reset then zero-wait imem returning 32'h00000413, idu_ready=1, wbu_valid with next_pc=0x80000004 in EXEC. Required: req_addr=0x80000000 in cycle 1, ifu_valid in cycle 3 with instr=0x00000413 and pc=0x80000000, next req_addr=0x80000004, fetch_cnt=1.
- req_ready held low 5 cycles, then resp_valid delayed 3 cycles. Required: req_addr stable throughout, exactly one request accepted, ifu_valid only after the response.
- idu_ready low 4 cycles in OUT. Required: ifu_valid, instr and pc stable; fetch_cnt increments exactly once on the handshake.
- next_pc=0x80000006. Required: no req_valid; ifu_valid next cycle with fetch_err=1, instr=0, pc=0x80000006.
- resp_err=1 with resp_data=0xDEADBEEF. Required: fetch_err=1, instr=0.
- rst asserted in WAIT and separately in OUT. Required: next cycle state=REQ, req_addr=RESET_PC, ifu_valid=0, fetch_cnt=0. A spurious wbu_valid in REQ does not alter pc.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch
// ---------
// Instruction fetch unit for the multi-cycle RV32E core.  It owns the
// architectural PC and fetches exactly one instruction per retired
// instruction.  Each instruction goes through four states:
//   REQ  - present pc on the imem request channel until it is accepted
//   WAIT - accept the imem response and latch instruction / fault
//   OUT  - offer instr/pc/fetch_err to decode until it takes them
//   EXEC - idle until writeback hands back the next PC
// A misaligned next PC is never sent to memory.  Instead the unit goes
// straight to OUT with a faulted, zeroed instruction at that PC.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_*          imem read request (valid/ready, word address)
//   resp_*         imem read response (valid/ready, data, access fault)
//   ifu_valid_o .. ifu_valid/idu_ready handshake towards decode carrying
//                  instr, pc and fetch_err
//   wbu_valid      writeback finished; next_pc is the following PC
//   fetch_cnt      number of completed decode handshakes (wraps)

module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [31:0]          req_addr,
  input  logic                 resp_valid,
  output logic                 resp_ready,
  input  logic [31:0]          resp_data,
  input  logic                 resp_err,
  output logic                 ifu_valid,
  input  logic                 idu_ready,
  output logic [31:0]          instr,
  output logic [31:0]          pc,
  output logic                 fetch_err,
  input  logic                 wbu_valid,
  input  logic [31:0]          next_pc,
  output logic [CNT_WIDTH-1:0] fetch_cnt
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [1:0] ST_EXEC = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next-state logic.  Each state only looks at the one input that
  // concerns it, so stray handshakes in other states are ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_REQ: begin
        if (req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (resp_valid) begin
          // A faulted response carries no usable instruction bits.
          instr_d = resp_err ? 32'h0 : resp_data;
          err_d   = resp_err;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (idu_ready) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (wbu_valid) begin
          pc_d = next_pc;
          if (next_pc[1:0] == 2'b00) begin
            state_d = ST_REQ;
          end else begin
            // Misaligned target: report the fault to decode without
            // touching the memory bus.
            instr_d = 32'h0;
            err_d   = 1'b1;
            state_d = ST_OUT;
          end
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State registers.  Reset wins over every other input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // All handshake outputs are decoded from the registered state only.
  // This keeps req_valid and ifu_valid free of combinational paths from
  // the ready inputs.
  assign req_valid  = (state_q == ST_REQ);
  assign req_addr   = (state_q == ST_REQ) ? pc_q : 32'h0;
  assign resp_ready = (state_q == ST_WAIT);
  assign ifu_valid  = (state_q == ST_OUT);
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign fetch_err  = err_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch.  The driver plays imem and writeback, and
// a decode process drives idu_ready.  Every fetch the bench causes is
// pushed into an expected queue.  A negedge monitor compares the decode
// side against that queue and against a model of the handshake counter.

module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CW       = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          ifu_valid;
  logic          idu_ready;
  logic [31:0]   instr;
  logic [31:0]   pc;
  logic          fetch_err;
  logic          wbu_valid;
  logic [31:0]   next_pc;
  logic [CW-1:0] fetch_cnt;

  int          checks       = 0;
  int          errors       = 0;
  int          hsCount      = 0;
  int          modelCnt     = 0;
  int          iduLowCnt    = 0;
  bit          iduRandom    = 0;
  bit          resetPending = 1;
  logic [31:0] modelPc      = RESET_PC;
  fetch_t      expQ[$];

  ifu_fetch #(.RESET_PC(RESET_PC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .ifu_valid(ifu_valid), .idu_ready(idu_ready),
    .instr(instr), .pc(pc), .fetch_err(fetch_err),
    .wbu_valid(wbu_valid), .next_pc(next_pc),
    .fetch_cnt(fetch_cnt)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every per-wait bound.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode model.  It is normally always ready.  It can be told to stall
  // a fixed number of OUT cycles, or to toggle idu_ready randomly.
  initial begin
    idu_ready = 1'b1;
    forever begin
      tick();
      if (ifu_valid && iduLowCnt > 0) begin
        idu_ready = 1'b0;
        iduLowCnt--;
      end else begin
        idu_ready = iduRandom ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Scoreboard monitor.  Inputs change just after posedge, so at negedge
  // the values seen are exactly the ones the DUT samples at the next edge.
  // Any queued fetch is checked on every OUT cycle, which also checks
  // that it stays stable.  It is popped only when a handshake completes
  // that reset does not override.
  always @(negedge clk) begin
    if (resetPending) begin
      expQ.delete();
      modelCnt = 0;
    end
    checkOutput("fetch_cnt", 32'(fetch_cnt), modelCnt);
    if (ifu_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_ifu_valid", 32'(ifu_valid), 32'h0);
      end else begin
        checkOutput("pc", pc, expQ[0].pc);
        checkOutput("instr", instr, expQ[0].instr);
        checkOutput("fetch_err", 32'(fetch_err), 32'(expQ[0].err));
        if (!rst && idu_ready) begin
          void'(expQ.pop_front());
          modelCnt = (modelCnt + 1) % (1 << CW);
          hsCount++;
        end
      end
    end
    resetPending = rst;
  end

  // Wait for the request, optionally hold req_ready low, then accept it.
  task automatic doRequest(input int reqDelay);
    int n;
    n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("req_valid_seen", 32'(req_valid), 32'h1);
    for (int i = 0; i < reqDelay; i++) begin
      req_ready = 1'b0;
      tick();
      checkOutput("req_valid_hold", 32'(req_valid), 32'h1);
      checkOutput("req_addr_hold", req_addr, modelPc);
    end
    checkOutput("req_addr", req_addr, modelPc);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  // Deliver the response after a delay and record what decode must see.
  task automatic doResponse(input int respDelay, input logic [31:0] data,
                            input logic err);
    fetch_t e;
    for (int i = 0; i < respDelay; i++) begin
      checkOutput("single_request", 32'(req_valid), 32'h0);
      checkOutput("no_early_ifu_valid", 32'(ifu_valid), 32'h0);
      tick();
    end
    checkOutput("resp_ready", 32'(resp_ready), 32'h1);
    resp_valid = 1'b1;
    resp_data  = data;
    resp_err   = err;
    e.pc    = modelPc;
    e.instr = err ? 32'h0 : data;
    e.err   = err;
    expQ.push_back(e);
    tick();
    resp_valid = 1'b0;
    resp_data  = $urandom;
    resp_err   = 1'b0;
    checkOutput("resp_to_ifu_valid", 32'(ifu_valid), 32'h1);
  endtask

  // Bounded wait for the monitor to count a new handshake, then confirm
  // the unit has gone quiet in EXEC.
  task automatic waitHandshake(input int start);
    int n;
    n = 0;
    while (hsCount <= start && n < 60) begin
      tick();
      n++;
    end
    checkOutput("handshake_seen", 32'(hsCount > start), 32'h1);
    checkOutput("exec_ifu_valid", 32'(ifu_valid), 32'h0);
    checkOutput("exec_req_valid", 32'(req_valid), 32'h0);
    checkOutput("exec_resp_ready", 32'(resp_ready), 32'h0);
    checkOutput("exec_req_addr", req_addr, 32'h0);
  endtask

  // Return the next PC from writeback.  A misaligned PC must produce a
  // faulted fetch on the next cycle with no memory request.
  task automatic doWriteback(input int wbDelay, input logic [31:0] nextPc);
    int start;
    fetch_t e;
    for (int i = 0; i < wbDelay; i++) begin
      tick();
      checkOutput("exec_idle", 32'(req_valid | ifu_valid), 32'h0);
    end
    start     = hsCount;
    wbu_valid = 1'b1;
    next_pc   = nextPc;
    modelPc   = nextPc;
    if (nextPc[1:0] != 2'b00) begin
      e.pc    = nextPc;
      e.instr = 32'h0;
      e.err   = 1'b1;
      expQ.push_back(e);
    end
    tick();
    wbu_valid = 1'b0;
    next_pc   = $urandom;
    if (nextPc[1:0] == 2'b00) begin
      checkOutput("wb_to_req_valid", 32'(req_valid), 32'h1);
      checkOutput("wb_req_addr", req_addr, nextPc);
    end else begin
      checkOutput("misaligned_no_req", 32'(req_valid), 32'h0);
      checkOutput("misaligned_ifu_valid", 32'(ifu_valid), 32'h1);
      waitHandshake(start);
    end
  endtask

  // One complete instruction: request, response, decode, writeback.
  task automatic applyStimulus(input int reqDelay, input int respDelay,
                               input logic [31:0] data, input logic err,
                               input int wbDelay, input logic [31:0] nextPc);
    int start;
    doRequest(reqDelay);
    start = hsCount;
    doResponse(respDelay, data, err);
    waitHandshake(start);
    doWriteback(wbDelay, nextPc);
  endtask

  // Main sequence: directed scenarios first, then randomized traffic.
  initial begin
    logic [31:0] rnd;
    logic [31:0] np;
    int          guard;
    rst        = 1'b1;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    resp_err   = 1'b0;
    wbu_valid  = 1'b0;
    next_pc    = 32'h0;
    repeat (3) tick();
    checkOutput("reset_req_valid", 32'(req_valid), 32'h1);
    checkOutput("reset_ifu_valid", 32'(ifu_valid), 32'h0);
    checkOutput("reset_fetch_err", 32'(fetch_err), 32'h0);
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_pc", pc, RESET_PC);
    rst = 1'b0;
    tick();
    checkOutput("first_req_valid", 32'(req_valid), 32'h1);
    checkOutput("first_req_addr", req_addr, RESET_PC);

    $display("[TB] zero-wait fetch");
    applyStimulus(0, 0, 32'h0000_0413, 1'b0, 0, 32'h8000_0004);
    checkOutput("cnt_after_first", 32'(fetch_cnt), 32'h1);

    $display("[TB] slow request and response");
    applyStimulus(5, 3, 32'h1234_5678, 1'b0, 2, 32'h8000_0008);

    $display("[TB] decode stall");
    iduLowCnt = 4;
    applyStimulus(0, 0, 32'h00A0_0093, 1'b0, 1, 32'h8000_000C);

    $display("[TB] misaligned next pc");
    applyStimulus(1, 1, 32'h0010_0113, 1'b0, 0, 32'h8000_0006);
    doWriteback(0, 32'h8000_0010);

    $display("[TB] bus error");
    applyStimulus(0, 2, 32'hDEAD_BEEF, 1'b1, 0, 32'h8000_0014);

    $display("[TB] reset in WAIT with response pending");
    doRequest(0);
    rst        = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'hCAFE_F00D;
    tick();
    rst        = 1'b0;
    resp_valid = 1'b0;
    modelPc    = RESET_PC;
    checkOutput("rst_wait_req_valid", 32'(req_valid), 32'h1);
    checkOutput("rst_wait_req_addr", req_addr, RESET_PC);
    checkOutput("rst_wait_ifu_valid", 32'(ifu_valid), 32'h0);
    checkOutput("rst_wait_cnt", 32'(fetch_cnt), 32'h0);

    $display("[TB] spurious writeback in REQ");
    wbu_valid = 1'b1;
    next_pc   = 32'h1234_5678;
    tick();
    wbu_valid = 1'b0;
    checkOutput("spurious_wb_req_addr", req_addr, RESET_PC);
    checkOutput("spurious_wb_pc", pc, RESET_PC);
    applyStimulus(0, 0, 32'h0000_0513, 1'b0, 0, 32'h8000_0020);

    $display("[TB] reset in OUT with decode ready");
    doRequest(0);
    doResponse(0, 32'h0000_0613, 1'b0);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    modelPc = RESET_PC;
    checkOutput("rst_out_req_valid", 32'(req_valid), 32'h1);
    checkOutput("rst_out_req_addr", req_addr, RESET_PC);
    checkOutput("rst_out_ifu_valid", 32'(ifu_valid), 32'h0);
    checkOutput("rst_out_cnt", 32'(fetch_cnt), 32'h0);
    checkOutput("rst_out_instr", instr, 32'h0);

    $display("[TB] randomized traffic");
    iduRandom = 1'b1;
    for (int it = 0; it < 50; it++) begin
      doRequest($urandom_range(0, 3));
      begin
        int start;
        start = hsCount;
        doResponse($urandom_range(0, 3), $urandom,
                   1'($urandom_range(0, 7) == 0));
        waitHandshake(start);
      end
      guard = 0;
      do begin
        rnd = $urandom;
        if ($urandom_range(0, 4) == 0) begin
          np = {rnd[31:2], 2'($urandom_range(1, 3))};
        end else begin
          np = {rnd[31:2], 2'b00};
        end
        if (guard >= 4) begin
          np = {rnd[31:2], 2'b00};
        end
        doWriteback($urandom_range(0, 2), np);
        guard++;
      end while (np[1:0] != 2'b00);
    end

    repeat (3) tick();
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
